rtc_calendar_core: RTL and testbench
====================================

Name: rtc_calendar_core

Overview:
Parametrised time/date counting core that replaces the discrete per-field counter chain in the clock top. It holds sec/min/hour/day/month/year and advances on an external 1 Hz enable. It supports per-field manual adjust, atomic load, full Gregorian leap rules, day clamping, a 12/24 h display view and one hour:minute alarm. Display formatting (BCD, 7-seg, blink) stays outside this block.

Parameters:
YEAR_W, 14, width of year value/ports
YEAR_MIN, 0, lowest year; wrap target
YEAR_MAX, 9999, highest year; must be < 2**YEAR_W and > YEAR_MIN
RST_YEAR, 2000, year after reset
RST_MONTH, 1, month after reset (1..12)
RST_DAY, 1, day after reset (1..dim)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick  in  1  1-cycle 1 Hz enable
run_en  in  1  enables auto counting
adj_field  in  3  0 none, 1 sec, 2 min, 3 hour, 4 day, 5 month, 6 year, 7 none
adj_up  in  1  1-cycle increment pulse for selected field
adj_down  in  1  1-cycle decrement pulse for selected field
load  in  1  1-cycle atomic load strobe
ld_sec, ld_min  in  6  load values
ld_hour  in  5  load value (0..23)
ld_day  in  5  load value
ld_month  in  4  load value
ld_year  in  YEAR_W  load value
mode_12h  in  1  selects hour_disp format
alarm_en  in  1  arms alarm
alarm_hour  in  5  0..23
alarm_min  in  6  0..59
alarm_ack  in  1  clears alarm_active
sec, min  out  6  0..59
hour  out  5  0..23 (always 24 h)
hour_disp  out  5  hour if mode_12h=0, else 1..12
pm  out  1  hour>=12 (valid in both modes)
day  out  5  1..dim
month  out  4  1..12
year  out  YEAR_W  YEAR_MIN..YEAR_MAX
leap  out  1  current year is leap
dim  out  5  days in current month (28..31)
load_err  out  1  1-cycle pulse: load rejected
alarm_hit  out  1  1-cycle pulse on alarm match
alarm_active  out  1  latched alarm flag

Behaviour:
- Reset: sec=min=hour=0, day=RST_DAY, month=RST_MONTH, year=RST_YEAR, load_err=0, alarm_hit=0, alarm_active=0. Reset overrides every other input.
- Priority per cycle: rst > load > adjust > tick. A lower-priority event in the same cycle is dropped; it is not queued.
- All field outputs are registered and update the cycle after the qualifying input. leap, dim, hour_disp and pm are combinational from registered state.
- Leap: (y%4==0 && y%100!=0) || y%400==0. Year 0 is leap. dim: Feb 28/29; Apr/Jun/Sep/Nov 30; others 31.
- Auto count: runs when tick && run_en && adj_field∈{0,7}.
  - sec wraps 59->0 and carries to min.
  - min wraps 59->0 and carries to hour.
  - hour wraps 23->0 and carries to day.
  - day wraps dim->1 and carries to month.
  - month wraps 12->1 and carries to year.
  - year wraps YEAR_MAX->YEAR_MIN.
  - The whole carry chain resolves in one cycle.
- Adjust: acts when exactly one of adj_up/adj_down is high and adj_field∈1..6. Both high does nothing.
  - Only the selected field changes, with wrap in both directions and no carry.
  - Ranges: sec/min 0..59, hour 0..23, day 1..dim, month 1..12, year YEAR_MIN..YEAR_MAX.
- Day clamp: after any month or year change (adjust, load or carry), if day > new dim then day = new dim. Example: 31-Jan adjusted to Feb becomes 28/29.
- Load: all fields are written in the same cycle.
  - Rejected entirely, state unchanged, load_err=1 for one cycle if any of: sec>59, min>59, hour>23, month∉1..12, year∉[YEAR_MIN,YEAR_MAX], day∉1..dim(ld_month, leap(ld_year)).
- 12 h view: hour 0 -> 12, 1..12 -> same, 13..23 -> hour-12.
- Alarm: alarm_hit pulses in the cycle after an auto-count step lands on sec==0 && min==alarm_min && hour==alarm_hour && alarm_en.
  - Adjust or load into the matching time does not fire the alarm.
  - alarm_hit sets alarm_active. alarm_ack clears it; a hit in the same cycle wins, so alarm_active stays 1.
  - alarm_en=0 does not clear alarm_active.

Test Plan:
- 9999-12-31 23:59:59, run_en=1, one tick -> next cycle 0000-01-01 00:00:00, leap=1.
- 2100-02-28 23:59:59 tick -> 2100-03-01 (leap=0). 2000-02-28 23:59:59 tick -> 2000-02-29 (leap=1).
- 2023-01-31, adj_field=5, adj_up -> 2023-02-28, hour/min/sec unchanged. Then adj_field=1 with sec=0, adj_down -> sec=59, min unchanged.
- Load 2024-02-30 -> load_err pulse, state unchanged. Load 2024-02-29 12:00:00 -> accepted, load_err=0. load+tick in the same cycle -> loaded value, no increment.
- mode_12h=1: hour=0 -> hour_disp=12, pm=0. hour=13 -> hour_disp=1, pm=1. hour=12 -> 12, pm=1.
- Alarm 07:30, time 07:29:59, tick -> alarm_hit pulse, alarm_active=1. alarm_ack -> 0. Load 07:30:00 -> no hit. Assert rst mid-count -> reset values the next cycle, alarm_active=0.

Source files
------------

// File: rtl/rtc_calendar_if.sv
// Control, load, alarm and calendar-field bundle between the clock top and rtc_calendar_core.
// Fields are level signals; the strobes (tick, adj_up/down, load, alarm_ack) are single-cycle, with no backpressure.
interface rtc_calendar_if #(
  parameter int YEAR_W = 14
);
  logic              tick;
  logic              run_en;
  logic [2:0]        adj_field;
  logic              adj_up;
  logic              adj_down;
  logic              load;
  logic [5:0]        ld_sec;
  logic [5:0]        ld_min;
  logic [4:0]        ld_hour;
  logic [4:0]        ld_day;
  logic [3:0]        ld_month;
  logic [YEAR_W-1:0] ld_year;
  logic              mode_12h;
  logic              alarm_en;
  logic [4:0]        alarm_hour;
  logic [5:0]        alarm_min;
  logic              alarm_ack;
  logic [5:0]        sec;
  logic [5:0]        min;
  logic [4:0]        hour;
  logic [4:0]        hour_disp;
  logic              pm;
  logic [4:0]        day;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic              leap;
  logic [4:0]        dim;
  logic              load_err;
  logic              alarm_hit;
  logic              alarm_active;

  modport master (
    output tick, run_en, adj_field, adj_up, adj_down, load,
           ld_sec, ld_min, ld_hour, ld_day, ld_month, ld_year,
           mode_12h, alarm_en, alarm_hour, alarm_min, alarm_ack,
    input  sec, min, hour, hour_disp, pm, day, month, year, leap, dim,
           load_err, alarm_hit, alarm_active
  );

  modport slave (
    input  tick, run_en, adj_field, adj_up, adj_down, load,
           ld_sec, ld_min, ld_hour, ld_day, ld_month, ld_year,
           mode_12h, alarm_en, alarm_hour, alarm_min, alarm_ack,
    output sec, min, hour, hour_disp, pm, day, month, year, leap, dim,
           load_err, alarm_hit, alarm_active
  );
endinterface

// File: rtl/rtc_calendar_core.sv
// Gregorian time/date counter with adjust, atomic load and one alarm; fields update 1 cycle after the input.
// No backpressure: priority rst > load > adjust > tick, losing events in the same cycle are dropped.
module rtc_calendar_core #(
  parameter int YEAR_W    = 14,
  parameter int YEAR_MIN  = 0,
  parameter int YEAR_MAX  = 9999,
  parameter int RST_YEAR  = 2000,
  parameter int RST_MONTH = 1,
  parameter int RST_DAY   = 1
) (
  input  logic           clk,
  input  logic           rst,
  rtc_calendar_if.slave  bus
);

  localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] Y_ONE = YEAR_W'(1);

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic [31:0] yy;
    yy = 32'(y);
    return (((yy % 32'd4) == 32'd0) && ((yy % 32'd100) != 32'd0)) || ((yy % 32'd400) == 32'd0);
  endfunction

  function automatic logic [4:0] days_in(input logic [3:0] m, input logic lp);
    logic [4:0] d;
    case (m)
      4'd2:                    d = lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  logic [5:0]        sec_q, min_q, sec_n, min_n;
  logic [4:0]        hour_q, day_q, hour_n, day_n;
  logic [3:0]        month_q, month_n;
  logic [YEAR_W-1:0] year_q, year_n;
  logic              load_err_q, alarm_hit_q, alarm_active_q;
  logic              load_err_n, alarm_hit_n, alarm_active_n;
  logic              leap_cur, load_ok, adj_act, cnt_act;
  logic [4:0]        dim_cur, dim_ld, dim_nxt;

  assign leap_cur = is_leap(year_q);
  assign dim_cur  = days_in(month_q, leap_cur);
  assign dim_ld   = days_in(bus.ld_month, is_leap(bus.ld_year));

  // Day range is checked against the month/year being loaded, not the current ones.
  assign load_ok = (bus.ld_sec <= 6'd59) && (bus.ld_min <= 6'd59) && (bus.ld_hour <= 5'd23)
                && (bus.ld_month >= 4'd1) && (bus.ld_month <= 4'd12)
                && ((32'(bus.ld_year) + 32'd1) > 32'(YEAR_MIN))
                && (32'(bus.ld_year) <= 32'(YEAR_MAX))
                && (bus.ld_day >= 5'd1) && (bus.ld_day <= dim_ld);

  assign adj_act = (bus.adj_up ^ bus.adj_down) && (bus.adj_field != 3'd0) && (bus.adj_field != 3'd7);
  assign cnt_act = bus.tick && bus.run_en && ((bus.adj_field == 3'd0) || (bus.adj_field == 3'd7));

  always_comb begin
    sec_n       = sec_q;
    min_n       = min_q;
    hour_n      = hour_q;
    day_n       = day_q;
    month_n     = month_q;
    year_n      = year_q;
    load_err_n  = 1'b0;
    alarm_hit_n = 1'b0;
    dim_nxt     = 5'd31;

    if (bus.load) begin
      if (load_ok) begin
        sec_n   = bus.ld_sec;
        min_n   = bus.ld_min;
        hour_n  = bus.ld_hour;
        day_n   = bus.ld_day;
        month_n = bus.ld_month;
        year_n  = bus.ld_year;
      end else begin
        load_err_n = 1'b1;
      end
    end else if (adj_act) begin
      case (bus.adj_field)
        3'd1: sec_n = bus.adj_down ? ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1)
                                   : ((sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1);
        3'd2: min_n = bus.adj_down ? ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1)
                                   : ((min_q >= 6'd59) ? 6'd0 : min_q + 6'd1);
        3'd3: hour_n = bus.adj_down ? ((hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1)
                                    : ((hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1);
        3'd4: day_n = bus.adj_down ? ((day_q <= 5'd1) ? dim_cur : day_q - 5'd1)
                                   : ((day_q >= dim_cur) ? 5'd1 : day_q + 5'd1);
        3'd5: month_n = bus.adj_down ? ((month_q <= 4'd1) ? 4'd12 : month_q - 4'd1)
                                     : ((month_q >= 4'd12) ? 4'd1 : month_q + 4'd1);
        3'd6: year_n = bus.adj_down ? ((year_q <= Y_MIN) ? Y_MAX : year_q - Y_ONE)
                                    : ((year_q >= Y_MAX) ? Y_MIN : year_q + Y_ONE);
        default: ;
      endcase
    end else if (cnt_act) begin
      if (sec_q < 6'd59) begin
        sec_n = sec_q + 6'd1;
      end else begin
        sec_n = 6'd0;
        if (min_q < 6'd59) begin
          min_n = min_q + 6'd1;
        end else begin
          min_n = 6'd0;
          if (hour_q < 5'd23) begin
            hour_n = hour_q + 5'd1;
          end else begin
            hour_n = 5'd0;
            if (day_q < dim_cur) begin
              day_n = day_q + 5'd1;
            end else begin
              day_n = 5'd1;
              if (month_q < 4'd12) begin
                month_n = month_q + 4'd1;
              end else begin
                month_n = 4'd1;
                year_n  = (year_q >= Y_MAX) ? Y_MIN : year_q + Y_ONE;
              end
            end
          end
        end
      end
      alarm_hit_n = bus.alarm_en && (sec_n == 6'd0) && (min_n == bus.alarm_min)
                 && (hour_n == bus.alarm_hour);
    end

    // A month or year change can leave the day past the end of the new month.
    dim_nxt = days_in(month_n, is_leap(year_n));
    if (day_n > dim_nxt) day_n = dim_nxt;

    alarm_active_n = alarm_hit_n | (alarm_active_q & ~bus.alarm_ack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q          <= 6'd0;
      min_q          <= 6'd0;
      hour_q         <= 5'd0;
      day_q          <= 5'(RST_DAY);
      month_q        <= 4'(RST_MONTH);
      year_q         <= YEAR_W'(RST_YEAR);
      load_err_q     <= 1'b0;
      alarm_hit_q    <= 1'b0;
      alarm_active_q <= 1'b0;
    end else begin
      sec_q          <= sec_n;
      min_q          <= min_n;
      hour_q         <= hour_n;
      day_q          <= day_n;
      month_q        <= month_n;
      year_q         <= year_n;
      load_err_q     <= load_err_n;
      alarm_hit_q    <= alarm_hit_n;
      alarm_active_q <= alarm_active_n;
    end
  end

  assign bus.sec          = sec_q;
  assign bus.min          = min_q;
  assign bus.hour         = hour_q;
  assign bus.day          = day_q;
  assign bus.month        = month_q;
  assign bus.year         = year_q;
  assign bus.leap         = leap_cur;
  assign bus.dim          = dim_cur;
  assign bus.pm           = (hour_q >= 5'd12);
  assign bus.hour_disp    = !bus.mode_12h    ? hour_q :
                            (hour_q == 5'd0) ? 5'd12  :
                            (hour_q > 5'd12) ? hour_q - 5'd12 : hour_q;
  assign bus.load_err     = load_err_q;
  assign bus.alarm_hit    = alarm_hit_q;
  assign bus.alarm_active = alarm_active_q;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Self-checking bench for rtc_calendar_core: load-vector table, directed corner sequences and
// randomized traffic compared every cycle against a seconds-of-day calendar model.
module tb_rtc_calendar_core;
  localparam int YW   = 14;
  localparam int YMIN = 0;
  localparam int YMAX = 9999;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rtc_calendar_if #(.YEAR_W(YW)) bus ();

  rtc_calendar_core #(
    .YEAR_W(YW), .YEAR_MIN(YMIN), .YEAR_MAX(YMAX),
    .RST_YEAR(2000), .RST_MONTH(1), .RST_DAY(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int y, mo, d, h, mi, s;
    int err, lp, dm, hd, pm;
  } vec_t;

  vec_t vt[12];
  int   nchk = 0;
  int   nerr = 0;
  int   m_y, m_mo, m_d, m_h, m_mi, m_s;
  int   m_err, m_hit, m_act;
  int   dm_tab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  function automatic int m_leap(int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int m_dim(int mo, int y);
    if (mo < 1 || mo > 12) return 31;
    if (mo == 2 && m_leap(y) != 0) return 29;
    return dm_tab[mo-1];
  endfunction

  task automatic check(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    int delta, span, dn, t;
    m_err = 0;
    m_hit = 0;
    if (rst) begin
      m_y = 2000; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0; m_act = 0;
      return;
    end
    if (bus.load) begin
      if (bus.ld_sec < 60 && bus.ld_min < 60 && bus.ld_hour < 24 &&
          int'(bus.ld_month) >= 1 && int'(bus.ld_month) <= 12 &&
          int'(bus.ld_year) >= YMIN && int'(bus.ld_year) <= YMAX &&
          int'(bus.ld_day) >= 1 && int'(bus.ld_day) <= m_dim(int'(bus.ld_month), int'(bus.ld_year))) begin
        m_y = int'(bus.ld_year); m_mo = int'(bus.ld_month); m_d = int'(bus.ld_day);
        m_h = int'(bus.ld_hour); m_mi = int'(bus.ld_min); m_s = int'(bus.ld_sec);
      end else begin
        m_err = 1;
      end
    end else if (bus.adj_up != bus.adj_down && bus.adj_field >= 1 && bus.adj_field <= 6) begin
      delta = bus.adj_up ? 1 : -1;
      dn    = m_dim(m_mo, m_y);
      span  = YMAX - YMIN + 1;
      case (int'(bus.adj_field))
        1: m_s  = (m_s + 60 + delta) % 60;
        2: m_mi = (m_mi + 60 + delta) % 60;
        3: m_h  = (m_h + 24 + delta) % 24;
        4: m_d  = (m_d - 1 + dn + delta) % dn + 1;
        5: m_mo = (m_mo - 1 + 12 + delta) % 12 + 1;
        default: m_y = YMIN + (m_y - YMIN + span + delta) % span;
      endcase
      if (m_d > m_dim(m_mo, m_y)) m_d = m_dim(m_mo, m_y);
    end else if (bus.tick && bus.run_en && (bus.adj_field == 0 || bus.adj_field == 7)) begin
      t = m_h * 3600 + m_mi * 60 + m_s + 1;
      if (t == 86400) begin
        t = 0;
        if (m_d < m_dim(m_mo, m_y)) m_d++;
        else begin
          m_d = 1;
          if (m_mo < 12) m_mo++;
          else begin
            m_mo = 1;
            m_y  = (m_y == YMAX) ? YMIN : m_y + 1;
          end
        end
      end
      m_h = t / 3600; m_mi = (t / 60) % 60; m_s = t % 60;
      if (bus.alarm_en && m_s == 0 && m_mi == int'(bus.alarm_min) && m_h == int'(bus.alarm_hour))
        m_hit = 1;
    end
    if (m_hit != 0) m_act = 1;
    else if (bus.alarm_ack) m_act = 0;
  endtask

  task automatic cycle();
    int hd;
    model_cycle();
    @(posedge clk);
    #1;
    hd = !bus.mode_12h ? m_h : ((m_h % 12 == 0) ? 12 : m_h % 12);
    check("sec", int'(bus.sec), m_s);
    check("min", int'(bus.min), m_mi);
    check("hour", int'(bus.hour), m_h);
    check("day", int'(bus.day), m_d);
    check("month", int'(bus.month), m_mo);
    check("year", int'(bus.year), m_y);
    check("leap", int'(bus.leap), m_leap(m_y));
    check("dim", int'(bus.dim), m_dim(m_mo, m_y));
    check("hour_disp", int'(bus.hour_disp), hd);
    check("pm", int'(bus.pm), (m_h >= 12) ? 1 : 0);
    check("load_err", int'(bus.load_err), m_err);
    check("alarm_hit", int'(bus.alarm_hit), m_hit);
    check("alarm_active", int'(bus.alarm_active), m_act);
    rst = 1'b0; bus.tick = 1'b0; bus.adj_up = 1'b0; bus.adj_down = 1'b0;
    bus.load = 1'b0; bus.alarm_ack = 1'b0;
  endtask

  task automatic set_ld(int y, int mo, int d, int h, int mi, int s);
    bus.ld_year = YW'(y); bus.ld_month = 4'(mo); bus.ld_day = 5'(d);
    bus.ld_hour = 5'(h);  bus.ld_min = 6'(mi);   bus.ld_sec = 6'(s);
    bus.load = 1'b1;
  endtask

  initial begin
    int r, y;
    int yl[5];
    yl = '{0, 1900, 2000, 2100, 9999};

    vt[0]  = '{2024, 2, 29, 12, 0, 0,    0, 1, 29, 12, 1};
    vt[1]  = '{2024, 2, 30, 12, 0, 0,    1, 1, 29, 12, 1};
    vt[2]  = '{2023, 2, 29, 0, 0, 0,     1, 1, 29, 12, 1};
    vt[3]  = '{2100, 2, 28, 13, 5, 0,    0, 0, 28, 1, 1};
    vt[4]  = '{2000, 4, 30, 0, 10, 0,    0, 1, 30, 12, 0};
    vt[5]  = '{2023, 13, 1, 0, 0, 0,     1, 1, 30, 12, 0};
    vt[6]  = '{2023, 6, 15, 23, 0, 60,   1, 1, 30, 12, 0};
    vt[7]  = '{2023, 11, 30, 11, 59, 59, 0, 0, 30, 11, 0};
    vt[8]  = '{1900, 2, 1, 24, 0, 0,     1, 0, 30, 11, 0};
    vt[9]  = '{1900, 1, 31, 1, 0, 0,     0, 0, 31, 1, 0};
    vt[10] = '{10000, 1, 1, 0, 0, 0,     1, 0, 31, 1, 0};
    vt[11] = '{2023, 9, 0, 0, 0, 0,      1, 0, 31, 1, 0};

    rst = 1'b1;
    bus.tick = 0; bus.run_en = 1; bus.adj_field = 0; bus.adj_up = 0; bus.adj_down = 0;
    bus.load = 0; bus.ld_sec = 0; bus.ld_min = 0; bus.ld_hour = 0; bus.ld_day = 1;
    bus.ld_month = 1; bus.ld_year = 0; bus.mode_12h = 0; bus.alarm_en = 0;
    bus.alarm_hour = 0; bus.alarm_min = 0; bus.alarm_ack = 0;

    cycle();
    check("rst_year", int'(bus.year), 2000);
    check("rst_day", int'(bus.day), 1);
    check("rst_sec", int'(bus.sec), 0);

    bus.mode_12h = 1;
    for (int i = 0; i < 12; i++) begin
      set_ld(vt[i].y, vt[i].mo, vt[i].d, vt[i].h, vt[i].mi, vt[i].s);
      cycle();
      check($sformatf("vec%0d_err", i), int'(bus.load_err), vt[i].err);
      check($sformatf("vec%0d_leap", i), int'(bus.leap), vt[i].lp);
      check($sformatf("vec%0d_dim", i), int'(bus.dim), vt[i].dm);
      check($sformatf("vec%0d_hdisp", i), int'(bus.hour_disp), vt[i].hd);
      check($sformatf("vec%0d_pm", i), int'(bus.pm), vt[i].pm);
    end
    bus.mode_12h = 0;

    set_ld(9999, 12, 31, 23, 59, 59); cycle();
    bus.tick = 1; cycle();
    check("yr_wrap_year", int'(bus.year), 0);
    check("yr_wrap_month", int'(bus.month), 1);
    check("yr_wrap_day", int'(bus.day), 1);
    check("yr_wrap_leap", int'(bus.leap), 1);

    set_ld(2100, 2, 28, 23, 59, 59); cycle();
    bus.tick = 1; cycle();
    check("y2100_month", int'(bus.month), 3);
    check("y2100_day", int'(bus.day), 1);
    set_ld(2000, 2, 28, 23, 59, 59); cycle();
    bus.tick = 1; cycle();
    check("y2000_day", int'(bus.day), 29);

    set_ld(2023, 1, 31, 10, 20, 0); cycle();
    bus.adj_field = 5; bus.adj_up = 1; cycle();
    check("clamp_day", int'(bus.day), 28);
    check("clamp_hour", int'(bus.hour), 10);
    bus.adj_field = 1; bus.adj_down = 1; cycle();
    check("sec_dn_wrap", int'(bus.sec), 59);
    check("sec_dn_min", int'(bus.min), 20);
    bus.adj_field = 0;

    set_ld(2024, 2, 29, 12, 0, 0); bus.tick = 1; cycle();
    check("load_beats_tick", int'(bus.sec), 0);

    bus.alarm_en = 1; bus.alarm_hour = 7; bus.alarm_min = 30;
    set_ld(2023, 5, 5, 7, 29, 59); cycle();
    bus.tick = 1; cycle();
    check("alarm_hit", int'(bus.alarm_hit), 1);
    check("alarm_act_set", int'(bus.alarm_active), 1);
    cycle();
    bus.alarm_ack = 1; cycle();
    check("alarm_ack", int'(bus.alarm_active), 0);
    set_ld(2023, 5, 5, 7, 30, 0); cycle();
    check("alarm_load_nohit", int'(bus.alarm_hit), 0);
    set_ld(2023, 5, 5, 7, 29, 59); cycle();
    bus.tick = 1; bus.alarm_ack = 1; cycle();
    check("alarm_hit_beats_ack", int'(bus.alarm_active), 1);
    bus.tick = 1; rst = 1; cycle();
    check("rst_mid_active", int'(bus.alarm_active), 0);
    check("rst_mid_min", int'(bus.min), 0);

    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      bus.run_en    = ($urandom_range(0, 9) != 0);
      bus.mode_12h  = 1'($urandom_range(0, 1));
      bus.tick      = 1'($urandom_range(0, 1));
      bus.adj_field = (r < 70) ? 3'd0 : 3'($urandom_range(0, 7));
      bus.alarm_ack = ($urandom_range(0, 15) == 0);
      if (r >= 70) begin
        bus.adj_up   = 1'($urandom_range(0, 1));
        bus.adj_down = 1'($urandom_range(0, 1));
      end
      if (r < 4) begin
        y = ($urandom_range(0, 3) == 0) ? yl[$urandom_range(0, 4)] : $urandom_range(0, 10100);
        set_ld(y, $urandom_range(0, 13), $urandom_range(0, 31), $urandom_range(0, 24),
               $urandom_range(0, 60), $urandom_range(0, 60));
      end else if (r == 5) begin
        y = yl[$urandom_range(0, 4)];
        r = $urandom_range(1, 12);
        set_ld(y, r, m_dim(r, y), 23, 59, $urandom_range(50, 59));
        bus.alarm_hour = 0; bus.alarm_min = 0;
        bus.alarm_en = ($urandom_range(0, 3) != 0);
      end else if (r == 6) begin
        bus.alarm_en = 1'($urandom_range(0, 1));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
